// File: rtl/pacman_pkg.sv
// Shared encodings for the Pacman character datapath: directions,
// character codes, coordinate type and the position-update FSM states.
package pacman_pkg;

  localparam int COORD_W   = 8;
  localparam int NUM_CHARS = 5;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    DIR_LEFT  = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_UP    = 2'd2,
    DIR_DOWN  = 2'd3
  } dir_e;

  localparam logic [2:0] CHAR_PACMAN = 3'd0;
  localparam logic [2:0] CHAR_GHOST1 = 3'd1;
  localparam logic [2:0] CHAR_GHOST2 = 3'd2;
  localparam logic [2:0] CHAR_GHOST3 = 3'd3;
  localparam logic [2:0] CHAR_GHOST4 = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_QUERY     = 3'd1,
    S_WAIT_RESP = 3'd2,
    S_WAIT_SAFE = 3'd3,
    S_COMMIT    = 3'd4
  } state_e;

endpackage

// File: rtl/move_target_calc.sv
// One-pixel move target: horizontal moves wrap through the tunnel,
// vertical moves off the legal range are flagged as blocked without a
// wall lookup, as are codes that name no character.
module move_target_calc
  import pacman_pkg::*;
#(
  parameter logic [7:0] X_MAX = 8'd115,
  parameter logic [7:0] Y_MAX = 8'd115
) (
  input  logic [7:0] cur_x,
  input  logic [7:0] cur_y,
  input  logic [1:0] dir,
  input  logic [2:0] char_id,
  output logic [7:0] tgt_x,
  output logic [7:0] tgt_y,
  output logic       early_block
);

  // Target coordinate and early-block decision for the requested direction.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    tgt_x       = cur_x;
    tgt_y       = cur_y;
    early_block = (char_id > CHAR_GHOST4);
    case (dir_e'(dir))
      DIR_LEFT:  tgt_x = (cur_x == 8'd0)  ? X_MAX : cur_x - 8'd1;
      DIR_RIGHT: tgt_x = (cur_x == X_MAX) ? 8'd0  : cur_x + 8'd1;
      DIR_UP: begin
        tgt_y = cur_y - 8'd1;
        if (cur_y == 8'd0) early_block = 1'b1;
      end
      DIR_DOWN: begin
        tgt_y = cur_y + 8'd1;
        if (cur_y == Y_MAX) early_block = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/character_position_registers.sv
// Position store for Pacman and the four ghosts. Move commands are checked
// against the maze, then written only while the display is not drawing
// the moving character so a sprite is never drawn half-moved.
module character_position_registers
  import pacman_pkg::*;
#(
  parameter logic [7:0] X_MAX  = 8'd115,
  parameter logic [7:0] Y_MAX  = 8'd115,
  parameter logic [7:0] PAC_X0 = 8'd56,
  parameter logic [7:0] PAC_Y0 = 8'd86,
  parameter logic [7:0] G1_X0  = 8'd56,
  parameter logic [7:0] G2_X0  = 8'd50,
  parameter logic [7:0] G3_X0  = 8'd56,
  parameter logic [7:0] G4_X0  = 8'd62,
  parameter logic [7:0] G1_Y0  = 8'd50,
  parameter logic [7:0] G2_Y0  = 8'd56,
  parameter logic [7:0] G3_Y0  = 8'd56,
  parameter logic [7:0] G4_Y0  = 8'd56
) (
  input  logic       clock_50,
  input  logic       reset,
  input  logic [2:0] character_type,
  output logic [7:0] char_x,
  output logic [7:0] char_y,
  output logic       pacman_orientation,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_char,
  input  logic [1:0] cmd_dir,
  output logic       wall_query_valid,
  output logic [7:0] wall_query_x,
  output logic [7:0] wall_query_y,
  input  logic       wall_resp_valid,
  input  logic       wall_blocked,
  output logic       cmd_done,
  output logic       cmd_blocked
);

  coord_t pos_x_q [NUM_CHARS];
  coord_t pos_y_q [NUM_CHARS];
  coord_t pos_x_d [NUM_CHARS];
  coord_t pos_y_d [NUM_CHARS];
  state_e state_q, state_d;
  logic   orient_q, orient_d;
  logic [2:0] lat_char_q, lat_char_d;
  coord_t tgt_x_q, tgt_x_d, tgt_y_q, tgt_y_d;
  logic   blocked_q, blocked_d;
  logic   wq_valid_q, wq_valid_d;
  coord_t wq_x_q, wq_x_d, wq_y_q, wq_y_d;
  logic   done_q, done_d;
  logic   cmd_blocked_q, cmd_blocked_d;

  coord_t sel_x, sel_y, calc_x, calc_y;
  logic   calc_early;

  // Combinational read port for the display and the move source mux.
  always_comb begin
    char_x = '0;
    char_y = '0;
    sel_x  = '0;
    sel_y  = '0;
    for (int i = 0; i < NUM_CHARS; i++) begin
      if (character_type == 3'(i)) begin
        char_x = pos_x_q[i];
        char_y = pos_y_q[i];
      end
      if (cmd_char == 3'(i)) begin
        sel_x = pos_x_q[i];
        sel_y = pos_y_q[i];
      end
    end
  end

  move_target_calc #(
    .X_MAX(X_MAX),
    .Y_MAX(Y_MAX)
  ) u_calc (
    .cur_x      (sel_x),
    .cur_y      (sel_y),
    .dir        (cmd_dir),
    .char_id    (cmd_char),
    .tgt_x      (calc_x),
    .tgt_y      (calc_y),
    .early_block(calc_early)
  );

  // Next-state logic for the move FSM, its outputs and the position store.
  always_comb begin
    state_d       = state_q;
    pos_x_d       = pos_x_q;
    pos_y_d       = pos_y_q;
    orient_d      = orient_q;
    lat_char_d    = lat_char_q;
    tgt_x_d       = tgt_x_q;
    tgt_y_d       = tgt_y_q;
    blocked_d     = blocked_q;
    wq_valid_d    = 1'b0;
    wq_x_d        = wq_x_q;
    wq_y_d        = wq_y_q;
    done_d        = 1'b0;
    cmd_blocked_d = cmd_blocked_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          lat_char_d = cmd_char;
          tgt_x_d    = calc_x;
          tgt_y_d    = calc_y;
          if (cmd_char == CHAR_PACMAN && dir_e'(cmd_dir) == DIR_LEFT)  orient_d = 1'b0;
          if (cmd_char == CHAR_PACMAN && dir_e'(cmd_dir) == DIR_RIGHT) orient_d = 1'b1;
          if (calc_early) begin
            blocked_d     = 1'b1;
            done_d        = 1'b1;
            cmd_blocked_d = 1'b1;
            state_d       = S_COMMIT;
          end else begin
            blocked_d  = 1'b0;
            wq_valid_d = 1'b1;
            wq_x_d     = calc_x;
            wq_y_d     = calc_y;
            state_d    = S_QUERY;
          end
        end
      end
      S_QUERY: begin
        if (wall_resp_valid) begin
          blocked_d = wall_blocked;
          state_d   = S_WAIT_SAFE;
        end else begin
          state_d = S_WAIT_RESP;
        end
      end
      S_WAIT_RESP: begin
        if (wall_resp_valid) begin
          blocked_d = wall_blocked;
          if (wall_blocked) begin
            done_d        = 1'b1;
            cmd_blocked_d = 1'b1;
            state_d       = S_COMMIT;
          end else begin
            state_d = S_WAIT_SAFE;
          end
        end
      end
      S_WAIT_SAFE: begin
        if (character_type != lat_char_q) begin
          done_d        = 1'b1;
          cmd_blocked_d = blocked_q;
          state_d       = S_COMMIT;
        end
      end
      S_COMMIT: begin
        if (!blocked_q) begin
          for (int i = 0; i < NUM_CHARS; i++) begin
            if (lat_char_q == 3'(i)) begin
              pos_x_d[i] = tgt_x_q;
              pos_y_d[i] = tgt_y_q;
            end
          end
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset restores home positions and drops any pending move.
  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) begin
      // NOTE: the position array is reset explicitly because the game relies on the home positions after reset.
      pos_x_q[CHAR_PACMAN] <= PAC_X0;
      pos_y_q[CHAR_PACMAN] <= PAC_Y0;
      pos_x_q[CHAR_GHOST1] <= G1_X0;
      pos_y_q[CHAR_GHOST1] <= G1_Y0;
      pos_x_q[CHAR_GHOST2] <= G2_X0;
      pos_y_q[CHAR_GHOST2] <= G2_Y0;
      pos_x_q[CHAR_GHOST3] <= G3_X0;
      pos_y_q[CHAR_GHOST3] <= G3_Y0;
      pos_x_q[CHAR_GHOST4] <= G4_X0;
      pos_y_q[CHAR_GHOST4] <= G4_Y0;
      state_q       <= S_IDLE;
      orient_q      <= 1'b0;
      lat_char_q    <= '0;
      tgt_x_q       <= '0;
      tgt_y_q       <= '0;
      blocked_q     <= 1'b0;
      wq_valid_q    <= 1'b0;
      wq_x_q        <= '0;
      wq_y_q        <= '0;
      done_q        <= 1'b0;
      cmd_blocked_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      pos_x_q       <= pos_x_d;
      pos_y_q       <= pos_y_d;
      state_q       <= state_d;
      orient_q      <= orient_d;
      lat_char_q    <= lat_char_d;
      tgt_x_q       <= tgt_x_d;
      tgt_y_q       <= tgt_y_d;
      blocked_q     <= blocked_d;
      wq_valid_q    <= wq_valid_d;
      wq_x_q        <= wq_x_d;
      wq_y_q        <= wq_y_d;
      done_q        <= done_d;
      cmd_blocked_q <= cmd_blocked_d;
    end
  end

  assign cmd_ready          = (state_q == S_IDLE);
  assign pacman_orientation = orient_q;
  assign wall_query_valid   = wq_valid_q;
  assign wall_query_x       = wq_x_q;
  assign wall_query_y       = wq_y_q;
  assign cmd_done           = done_q;
  assign cmd_blocked        = cmd_blocked_q;

endmodule

// File: tb/tb_character_position_registers.sv
// Directed bench for character_position_registers: a table of move
// commands with hand-computed results, then tunnel wrap, top-edge block
// and reset-abort sequences.
module tb_character_position_registers;

  logic       clock_50 = 1'b0;
  logic       reset;
  logic [2:0] character_type;
  logic [7:0] char_x, char_y;
  logic       pacman_orientation;
  logic       cmd_valid, cmd_ready;
  logic [2:0] cmd_char;
  logic [1:0] cmd_dir;
  logic       wall_query_valid;
  logic [7:0] wall_query_x, wall_query_y;
  logic       wall_resp_valid, wall_blocked;
  logic       cmd_done, cmd_blocked;

  int n_total = 0;
  int n_pass  = 0;

  character_position_registers dut (
    .clock_50          (clock_50),
    .reset             (reset),
    .character_type    (character_type),
    .char_x            (char_x),
    .char_y            (char_y),
    .pacman_orientation(pacman_orientation),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_char          (cmd_char),
    .cmd_dir           (cmd_dir),
    .wall_query_valid  (wall_query_valid),
    .wall_query_x      (wall_query_x),
    .wall_query_y      (wall_query_y),
    .wall_resp_valid   (wall_resp_valid),
    .wall_blocked      (wall_blocked),
    .cmd_done          (cmd_done),
    .cmd_blocked       (cmd_blocked)
  );

  always #5 clock_50 = ~clock_50;

  typedef struct {
    logic [2:0] ch;
    logic [1:0] dir;
    int         k;        // response delay after the query cycle
    logic       blk;      // wall answer
    logic [2:0] hold;     // character_type shown while t < rel
    int         rel;
    int         exp_q;    // expected number of query pulses
    logic [7:0] exp_qx, exp_qy;
    int         exp_lat;  // cycles from handshake to cmd_done
    logic       exp_blk;
    logic [7:0] exp_x, exp_y;
    logic       exp_or;
  } vec_t;

  typedef struct {
    logic       rdy;
    int         q_cnt;
    logic [7:0] qx, qy;
    int         done_t;
    logic       blocked;
    logic [7:0] fx, fy;
    logic       orient;
  } obs_t;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Issue one command, play the wall responder, then read the result back.
  task automatic run_cmd(input logic [2:0] ch, input logic [1:0] dir, input int k,
                         input logic blk, input logic [2:0] hold, input int rel,
                         output obs_t o);
    int t;
    int qt;
    o.q_cnt = 0; o.qx = '0; o.qy = '0; o.done_t = -1; o.blocked = 1'b0;
    qt = 0;
    @(negedge clock_50);
    o.rdy = cmd_ready;
    cmd_valid = 1'b1; cmd_char = ch; cmd_dir = dir;
    character_type = (rel > 0) ? hold : 3'd7;
    t = 0;
    while (o.done_t < 0 && t < 60) begin
      @(negedge clock_50);
      t++;
      cmd_valid = 1'b0;
      wall_resp_valid = 1'b0;
      if (wall_query_valid) begin
        o.q_cnt++; o.qx = wall_query_x; o.qy = wall_query_y; qt = t;
      end
      if (cmd_done) begin
        o.done_t = t; o.blocked = cmd_blocked;
      end
      if (o.q_cnt > 0 && t == qt + k && o.done_t < 0) begin
        wall_resp_valid = 1'b1; wall_blocked = blk;
      end
      character_type = (t < rel) ? hold : 3'd7;
    end
    wall_resp_valid = 1'b0;
    character_type  = 3'd7;
    @(negedge clock_50);
    character_type = ch;
    #1;
    o.fx = char_x; o.fy = char_y; o.orient = pacman_orientation;
    character_type = 3'd7;
  endtask

  vec_t vecs[9];
  logic [7:0] def_x[5];
  logic [7:0] def_y[5];

  initial begin
    obs_t o;
    int   done_seen;

    def_x = '{8'd56, 8'd56, 8'd50, 8'd56, 8'd62};
    def_y = '{8'd86, 8'd50, 8'd56, 8'd56, 8'd56};

    //           ch    dir  k  blk  hold  rel q  qx     qy     lat blk  x      y      or
    vecs[0] = '{3'd0, 2'd1, 2, 1'b0, 3'd3, 99, 1, 8'd57, 8'd86, 5,  1'b0, 8'd57, 8'd86, 1'b1};
    vecs[1] = '{3'd0, 2'd0, 1, 1'b1, 3'd3, 99, 1, 8'd56, 8'd86, 3,  1'b1, 8'd57, 8'd86, 1'b0};
    vecs[2] = '{3'd1, 2'd2, 3, 1'b0, 3'd7, 0,  1, 8'd56, 8'd49, 6,  1'b0, 8'd56, 8'd49, 1'b0};
    vecs[3] = '{3'd3, 2'd3, 1, 1'b0, 3'd7, 0,  1, 8'd56, 8'd57, 4,  1'b0, 8'd56, 8'd57, 1'b0};
    vecs[4] = '{3'd4, 2'd1, 1, 1'b1, 3'd7, 0,  1, 8'd63, 8'd56, 3,  1'b1, 8'd62, 8'd56, 1'b0};
    vecs[5] = '{3'd6, 2'd0, 1, 1'b0, 3'd7, 0,  0, 8'd0,  8'd0,  1,  1'b1, 8'd0,  8'd0,  1'b0};
    vecs[6] = '{3'd0, 2'd3, 0, 1'b0, 3'd7, 0,  1, 8'd57, 8'd87, 3,  1'b0, 8'd57, 8'd87, 1'b0};
    vecs[7] = '{3'd2, 2'd0, 1, 1'b0, 3'd2, 10, 1, 8'd49, 8'd56, 11, 1'b0, 8'd49, 8'd56, 1'b0};
    vecs[8] = '{3'd3, 2'd2, 0, 1'b1, 3'd7, 0,  1, 8'd56, 8'd56, 3,  1'b1, 8'd56, 8'd57, 1'b0};

    reset = 1'b1; character_type = 3'd7; cmd_valid = 1'b0; cmd_char = '0; cmd_dir = '0;
    wall_resp_valid = 1'b0; wall_blocked = 1'b0;
    repeat (3) @(negedge clock_50);
    reset = 1'b0;

    // Reset state
    for (int i = 0; i < 5; i++) begin
      character_type = 3'(i);
      #1;
      check($sformatf("reset_x%0d", i), int'(char_x), int'(def_x[i]));
      check($sformatf("reset_y%0d", i), int'(char_y), int'(def_y[i]));
    end
    character_type = 3'd7;
    check("reset_orient", int'(pacman_orientation), 0);
    check("reset_ready", int'(cmd_ready), 1);
    check("reset_done", int'(cmd_done), 0);
    check("reset_qvalid", int'(wall_query_valid), 0);
    check("reset_blocked", int'(cmd_blocked), 0);
    check("reset_qx", int'(wall_query_x), 0);

    // Table of single commands
    for (int i = 0; i < 9; i++) begin
      run_cmd(vecs[i].ch, vecs[i].dir, vecs[i].k, vecs[i].blk, vecs[i].hold, vecs[i].rel, o);
      check($sformatf("v%0d_ready", i), int'(o.rdy), 1);
      check($sformatf("v%0d_qcount", i), o.q_cnt, vecs[i].exp_q);
      if (vecs[i].exp_q > 0) begin
        check($sformatf("v%0d_qx", i), int'(o.qx), int'(vecs[i].exp_qx));
        check($sformatf("v%0d_qy", i), int'(o.qy), int'(vecs[i].exp_qy));
      end
      check($sformatf("v%0d_latency", i), o.done_t, vecs[i].exp_lat);
      check($sformatf("v%0d_blocked", i), int'(o.blocked), int'(vecs[i].exp_blk));
      check($sformatf("v%0d_x", i), int'(o.fx), int'(vecs[i].exp_x));
      check($sformatf("v%0d_y", i), int'(o.fy), int'(vecs[i].exp_y));
      check($sformatf("v%0d_orient", i), int'(o.orient), int'(vecs[i].exp_or));
    end

    // Tunnel: Pacman from x=57 walks right to X_MAX, then wraps both ways
    for (int i = 0; i < 58; i++) run_cmd(3'd0, 2'd1, 1, 1'b0, 3'd7, 0, o);
    check("walk_to_xmax_x", int'(o.fx), 115);
    run_cmd(3'd0, 2'd1, 1, 1'b0, 3'd7, 0, o);
    check("wrap_right_qx", int'(o.qx), 0);
    check("wrap_right_qy", int'(o.qy), 87);
    check("wrap_right_x", int'(o.fx), 0);
    check("wrap_right_orient", int'(o.orient), 1);
    run_cmd(3'd0, 2'd0, 1, 1'b0, 3'd7, 0, o);
    check("wrap_left_qx", int'(o.qx), 115);
    check("wrap_left_x", int'(o.fx), 115);
    check("wrap_left_orient", int'(o.orient), 0);

    // Ghost 1 climbs from y=49 to y=0, then an up move is refused without a query
    for (int i = 0; i < 49; i++) run_cmd(3'd1, 2'd2, 1, 1'b0, 3'd7, 0, o);
    check("climb_y", int'(o.fy), 0);
    run_cmd(3'd1, 2'd2, 1, 1'b0, 3'd7, 0, o);
    check("top_edge_qcount", o.q_cnt, 0);
    check("top_edge_latency", o.done_t, 1);
    check("top_edge_blocked", int'(o.blocked), 1);
    check("top_edge_x", int'(o.fx), 56);
    check("top_edge_y", int'(o.fy), 0);

    // Reset while waiting for the wall answer, followed by a stale answer
    @(negedge clock_50);
    cmd_valid = 1'b1; cmd_char = 3'd0; cmd_dir = 2'd1;
    @(negedge clock_50);
    cmd_valid = 1'b0;
    check("abort_query_pulse", int'(wall_query_valid), 1);
    @(negedge clock_50);
    check("abort_waiting", int'(cmd_ready), 0);
    reset = 1'b1;
    @(negedge clock_50);
    reset = 1'b0;
    wall_resp_valid = 1'b1; wall_blocked = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock_50);
      wall_resp_valid = 1'b0;
      if (cmd_done) done_seen++;
    end
    check("abort_no_done", done_seen, 0);
    check("abort_ready", int'(cmd_ready), 1);
    check("abort_blocked", int'(cmd_blocked), 0);
    check("abort_orient", int'(pacman_orientation), 0);
    check("abort_qx", int'(wall_query_x), 0);
    for (int i = 0; i < 5; i++) begin
      character_type = 3'(i);
      #1;
      check($sformatf("abort_x%0d", i), int'(char_x), int'(def_x[i]));
      check($sformatf("abort_y%0d", i), int'(char_y), int'(def_y[i]));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
